// File: rtl/md_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: operation codes, FSM states
// and the write-back md_control value that selects HI.
package md_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MTHI  = 3'b100,
        MD_MTLO  = 3'b101
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } md_state_t;

    localparam logic [2:0] MD_SEL_HI = 3'b110;

endpackage

// File: rtl/md_div_step.sv
// One restoring-divide step: shift the next dividend bit into the partial remainder
// and subtract the divisor when it fits.
module md_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             msb_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);
    import md_pkg::*;

    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] diff_s;

    // Remainder < divisor keeps both branches inside WIDTH bits; the top diff bit is the borrow.
    always_comb begin
        shifted_s = {rem_i, msb_i};
        diff_s    = shifted_s - {1'b0, divisor_i};
        if (diff_s[WIDTH] == 1'b0) begin
            rem_o   = diff_s[WIDTH-1:0];
            q_bit_o = 1'b1;
        end else begin
            rem_o   = shifted_s[WIDTH-1:0];
            q_bit_o = 1'b0;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MIPS HI/LO multiply/divide unit. Define MDU_FAST_MUL_EN to replace the
// shift-add multiply with a single-cycle product (2-cycle multiply latency).
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             div_zero
);
    import md_pkg::*;

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    md_state_t          state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic               neg_q_q, neg_q_d, neg_r_q, neg_r_d;
    logic               is_mul_q, is_mul_d, dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               busy_q, busy_d, done_q, done_d, div_zero_q, div_zero_d;

    md_op_t             op_s;
    logic               signed_op_s, b_zero_s, q_bit_s;
    logic [WIDTH-1:0]   rem_next_s;

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? ({WIDTH{1'b0}} - v) : v;
    endfunction

    assign op_s        = md_op_t'(op);
    assign signed_op_s = (op_s == MD_MULT) || (op_s == MD_DIV);
    assign b_zero_s    = (b == {WIDTH{1'b0}});

    // p_q holds {partial remainder, dividend/quotient} while dividing.
    md_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i     (p_q[2*WIDTH-1:WIDTH]),
        .msb_i     (p_q[WIDTH-1]),
        .divisor_i (mcand_q),
        .rem_o     (rem_next_s),
        .q_bit_o   (q_bit_s)
    );

`ifndef MDU_FAST_MUL_EN
    logic [WIDTH:0] mul_sum_s;
    assign mul_sum_s = {1'b0, p_q[2*WIDTH-1:WIDTH]}
                     + (p_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= IDLE;
            cnt_q      <= {CW{1'b0}};
            mcand_q    <= {WIDTH{1'b0}};
            p_q        <= {(2*WIDTH){1'b0}};
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            is_mul_q   <= 1'b0;
            dz_q       <= 1'b0;
            hi_q       <= {WIDTH{1'b0}};
            lo_q       <= {WIDTH{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mcand_q    <= mcand_d;
            p_q        <= p_d;
            neg_q_q    <= neg_q_d;
            neg_r_q    <= neg_r_d;
            is_mul_q   <= is_mul_d;
            dz_q       <= dz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    // Next-state logic; flush overrides everything, including a same-cycle start.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        case (op_s)
                            MD_MULT, MD_MULTU: state_d = MUL;
                            MD_DIV, MD_DIVU:   state_d = b_zero_s ? FIX : DIV;
                            default:           state_d = IDLE;
                        endcase
                    end else begin
                        state_d = IDLE;
                    end
                end
`ifdef MDU_FAST_MUL_EN
                MUL:     state_d = FIX;
`else
                MUL:     state_d = (cnt_q == CNT_LAST) ? FIX : MUL;
`endif
                DIV:     state_d = (cnt_q == CNT_LAST) ? FIX : DIV;
                FIX:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath and output next values.
    always_comb begin
        cnt_d      = cnt_q;
        mcand_d    = mcand_q;
        p_d        = p_q;
        neg_q_d    = neg_q_q;
        neg_r_d    = neg_r_q;
        is_mul_d   = is_mul_q;
        dz_d       = dz_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
        if (flush) begin
            busy_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        case (op_s)
                            MD_MULT, MD_MULTU: begin
                                mcand_d    = abs_val(a, signed_op_s);
                                p_d        = {{WIDTH{1'b0}}, abs_val(b, signed_op_s)};
                                neg_q_d    = signed_op_s & (a[WIDTH-1] ^ b[WIDTH-1]);
                                neg_r_d    = signed_op_s & a[WIDTH-1];
                                is_mul_d   = 1'b1;
                                dz_d       = 1'b0;
                                cnt_d      = {CW{1'b0}};
                                busy_d     = 1'b1;
                                div_zero_d = 1'b0;
                            end
                            MD_DIV, MD_DIVU: begin
                                mcand_d    = abs_val(b, signed_op_s);
                                neg_q_d    = signed_op_s & (a[WIDTH-1] ^ b[WIDTH-1]);
                                neg_r_d    = signed_op_s & a[WIDTH-1];
                                is_mul_d   = 1'b0;
                                dz_d       = b_zero_s;
                                cnt_d      = {CW{1'b0}};
                                busy_d     = 1'b1;
                                div_zero_d = 1'b0;
                                // Divide by zero parks the final HI/LO pattern in p_q for FIX.
                                if (b_zero_s) begin
                                    p_d = {a, {WIDTH{1'b1}}};
                                end else begin
                                    p_d = {{WIDTH{1'b0}}, abs_val(a, signed_op_s)};
                                end
                            end
                            MD_MTHI: begin
                                hi_d       = a;
                                done_d     = 1'b1;
                                div_zero_d = 1'b0;
                            end
                            MD_MTLO: begin
                                lo_d       = a;
                                done_d     = 1'b1;
                                div_zero_d = 1'b0;
                            end
                            default: busy_d = 1'b0;
                        endcase
                    end else begin
                        busy_d = 1'b0;
                    end
                end
                MUL: begin
`ifdef MDU_FAST_MUL_EN
                    p_d = {{WIDTH{1'b0}}, mcand_q} * {{WIDTH{1'b0}}, p_q[WIDTH-1:0]};
`else
                    p_d = {mul_sum_s, p_q[WIDTH-1:1]};
`endif
                    cnt_d = cnt_q + CW'(1);
                end
                DIV: begin
                    p_d   = {rem_next_s, p_q[WIDTH-2:0], q_bit_s};
                    cnt_d = cnt_q + CW'(1);
                end
                FIX: begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    if (dz_q) begin
                        hi_d       = p_q[2*WIDTH-1:WIDTH];
                        lo_d       = p_q[WIDTH-1:0];
                        div_zero_d = 1'b1;
                    end else if (is_mul_q) begin
                        {hi_d, lo_d} = neg_q_q ? ({(2*WIDTH){1'b0}} - p_q) : p_q;
                    end else begin
                        lo_d = neg_q_q ? ({WIDTH{1'b0}} - p_q[WIDTH-1:0]) : p_q[WIDTH-1:0];
                        hi_d = neg_r_q ? ({WIDTH{1'b0}} - p_q[2*WIDTH-1:WIDTH])
                                       : p_q[2*WIDTH-1:WIDTH];
                    end
                end
                default: busy_d = 1'b0;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign res_hi   = hi_q;
    assign res_lo   = lo_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit; latencies follow MDU_FAST_MUL_EN when defined.
module tb_mul_div_unit;

`ifdef MDU_FAST_MUL_EN
    localparam int ML = 2;
    localparam int FLUSH_AT = 2;
`else
    localparam int ML = 33;
    localparam int FLUSH_AT = 10;
`endif

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = 32'h0;
    logic [31:0] b = 32'h0;
    logic        flush = 1'b0;
    logic        busy, done, div_zero;
    logic [31:0] res_hi, res_lo;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .clrn(clrn), .start(start), .op(op), .a(a), .b(b), .flush(flush),
        .busy(busy), .done(done), .res_hi(res_hi), .res_lo(res_lo), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issues one op and counts clock edges from the accept edge (0) to the edge that raised done.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int lat);
        op = o; a = x; b = y; start = 1'b1;
        lat = -1;
        for (int e = 0; e < 100; e++) begin
            @(posedge clk); #1;
            if (e == 0) start = 1'b0;
            if (done) begin
                lat = e;
                break;
            end
        end
        @(posedge clk); #1;
        check("done_single_pulse", {31'b0, done}, 32'h0);
        check("busy_after_done", {31'b0, busy}, 32'h0);
    endtask

    initial begin
        int lat;
        int done_seen;

        vecs[0]  = '{3'b000, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, ML};
        vecs[1]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, ML};
        vecs[2]  = '{3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
        vecs[3]  = '{3'b011, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0, 33};
        vecs[4]  = '{3'b011, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1, 1};
        vecs[5]  = '{3'b101, 32'h00000005, 32'h00000000, 32'h00001234, 32'h00000005, 1'b0, 0};
        vecs[6]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
        vecs[7]  = '{3'b000, 32'h00000006, 32'h00000007, 32'h00000000, 32'h0000002A, 1'b0, ML};
        vecs[8]  = '{3'b100, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 32'h0000002A, 1'b0, 0};
        vecs[9]  = '{3'b010, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33};
        vecs[10] = '{3'b010, 32'h00000000, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1};
        vecs[11] = '{3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, ML};
        vecs[12] = '{3'b011, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0, 33};
        vecs[13] = '{3'b001, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, ML};

        #12;
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_done", {31'b0, done}, 32'h0);
        check("reset_hi", res_hi, 32'h0);
        check("reset_lo", res_lo, 32'h0);
        check("reset_dz", {31'b0, div_zero}, 32'h0);
        @(posedge clk); #1;
        clrn = 1'b1;
        @(posedge clk); #1;

        // Multiply busy is visible right after the accept edge.
        op = 3'b000; a = 32'd2; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_accept", {31'b0, busy}, 32'h1);
        for (int e = 0; e < 60 && busy; e++) begin
            @(posedge clk); #1;
        end
        check("first_mult_lo", res_lo, 32'h6);
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_hi", i), res_hi, vecs[i].hi);
            check($sformatf("v%0d_lo", i), res_lo, vecs[i].lo);
            check($sformatf("v%0d_dz", i), {31'b0, div_zero}, {31'b0, vecs[i].dz});
        end

        // Flush mid-multiply, with a stray start while busy; HI/LO stay at 1/0.
        op = 3'b000; a = 32'd6; b = 32'd7; start = 1'b1;
        done_seen = 0;
        for (int e = 0; e < 60; e++) begin
            @(posedge clk); #1;
            if (done) done_seen++;
            if (e == 0) begin
                op = 3'b100; a = 32'h55; start = 1'b1;
            end
            if (e == 1) start = 1'b0;
            if (e == FLUSH_AT - 1) flush = 1'b1;
            if (e == FLUSH_AT) begin
                flush = 1'b0;
                check("flush_busy_low", {31'b0, busy}, 32'h0);
            end
        end
        check("flush_no_done", 32'(done_seen), 32'h0);
        check("flush_hi_kept", res_hi, 32'h1);
        check("flush_lo_kept", res_lo, 32'h0);

        // Flush and start in the same idle cycle: not accepted.
        op = 3'b100; a = 32'h77; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(posedge clk); #1;
        check("flush_start_busy", {31'b0, busy}, 32'h0);
        check("flush_start_hi", res_hi, 32'h1);

        // Asynchronous reset in the middle of a divide.
        op = 3'b011; a = 32'd100; b = 32'd7; start = 1'b1;
        for (int e = 0; e < 5; e++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        check("pre_reset_busy", {31'b0, busy}, 32'h1);
        clrn = 1'b0;
        #1;
        check("midop_reset_busy", {31'b0, busy}, 32'h0);
        check("midop_reset_hi", res_hi, 32'h0);
        check("midop_reset_lo", res_lo, 32'h0);
        @(posedge clk); #1;
        clrn = 1'b1;
        @(posedge clk); #1;
        run_op(3'b001, 32'd3, 32'd5, lat);
        check("post_reset_lat", 32'(lat), 32'(ML));
        check("post_reset_lo", res_lo, 32'd15);
        check("post_reset_hi", res_hi, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
